stage_queue: RTL

//  Parametrised valid/ready FIFO carrying one decoded instruction per entry.

---
 rtl/stage_queue_pkg.sv | 31 +++
 rtl/stage_queue_wrap_ptr.sv | 21 ++
 rtl/stage_queue.sv | 108 ++++++++++
 3 files changed

// File: rtl/stage_queue_pkg.sv
// Decoded-instruction types shared by the decode/execute boundary, plus the
// queue entry layout carried by stage_queue.
package stageinfo;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } StageInfo;

    typedef struct packed {
        logic [3:0] alu_op;
        logic [4:0] rd;
        logic       reg_we;
        logic       mem_re;
        logic       mem_we;
    } Ctrl;

    typedef struct packed {
        logic       valid;
        logic [4:0] cause;
    } TrapInfo;

    typedef struct packed {
        StageInfo info;
        Ctrl      ctrl;
        TrapInfo  trap;
    } QueueEntry;

    localparam int QUEUE_ENTRY_W = $bits(QueueEntry);

endpackage

// File: rtl/stage_queue_wrap_ptr.sv
// Wrapping index counter 0..DEPTH-1 with synchronous reset and clear.
module wrap_ptr #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       inc,
    output logic [$clog2(DEPTH)-1:0]   ptr
);

    localparam int PW = $clog2(DEPTH);

    always_ff @(posedge clk) begin
        if (reset || clear)
            ptr <= '0;
        else if (inc)
            ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    end

endmodule

// File: rtl/stage_queue.sv
// Decode->execute valid/ready instruction queue with flush and trap serialisation.
// Define STAGE_QUEUE_BYPASS_EN for same-cycle pass-through when the queue is empty.
module stage_queue
    import stageinfo::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           enq_valid,
    output logic                           enq_ready,
    input  logic [QUEUE_ENTRY_W-1:0]       enq_entry,
    output logic                           deq_valid,
    input  logic                           deq_ready,
    output logic [QUEUE_ENTRY_W-1:0]       deq_entry,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           trap_held
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    QueueEntry          mem [DEPTH];
    QueueEntry          enq_e;
    QueueEntry          head_e;
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      wr_ptr;
    logic [CW-1:0]      count_q;
    logic               trap_held_q;
    logic               empty;
    logic               full;
    logic               byp_avail;
    logic               byp_take;
    logic               enq_fire;
    logic               deq_fire;
    logic               wr_inc;
    logic               rd_inc;

    assign enq_e  = QueueEntry'(enq_entry);
    assign head_e = mem[rd_ptr];
    assign empty  = (count_q == '0);
    assign full   = (count_q == CW'(DEPTH));

`ifdef STAGE_QUEUE_BYPASS_EN
    assign byp_avail = empty && enq_valid && !trap_held_q && !flush;
`else
    assign byp_avail = 1'b0;
`endif

    // enq_ready looks only at state, so a full queue refuses even when the head leaves
    assign enq_ready = !full && !trap_held_q;
    assign deq_valid = (!empty && !flush) || byp_avail;

    always_comb begin
        deq_entry = '0;
        if (!empty)
            deq_entry = head_e;
        else if (byp_avail)
            deq_entry = enq_entry;
    end

    assign enq_fire = enq_valid && enq_ready && !flush;
    assign deq_fire = deq_valid && deq_ready && !flush;
    // a bypassed entry consumed in the same cycle never touches storage
    assign byp_take = byp_avail && deq_ready;
    assign wr_inc   = enq_fire && !byp_take;
    assign rd_inc   = deq_fire && !byp_take;

    wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .inc   (rd_inc),
        .ptr   (rd_ptr)
    );

    wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .inc   (wr_inc),
        .ptr   (wr_ptr)
    );

    always_ff @(posedge clk) begin
        if (wr_inc)
            mem[wr_ptr] <= enq_e;
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            count_q     <= '0;
            trap_held_q <= 1'b0;
        end else begin
            count_q <= count_q + CW'(wr_inc) - CW'(rd_inc);
            // a trapping entry is always the youngest, so set and clear never coincide
            if (wr_inc && enq_e.trap.valid)
                trap_held_q <= 1'b1;
            else if (rd_inc && head_e.trap.valid)
                trap_held_q <= 1'b0;
        end
    end

    assign count     = count_q;
    assign trap_held = trap_held_q;

endmodule
